board_io_ctrl: RTL

//  Board-level glue between FPGA pins and the sigma SoC, parametrised over button/switch/LED counts.

---
 rtl/board_io_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Board glue between FPGA pins and the sigma SoC: SoC reset sequencing from board reset and PLL lock,
// button/switch synchronise + debounce, press pulses, sticky button IRQs and a reset-time LED status.
module board_io_ctrl #(
    parameter int                NUM_BTN         = 5,
    parameter int                NUM_SW          = 16,
    parameter int                NUM_LED         = 16,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 250000,
    parameter int                RST_HOLD_CYCLES = 1024,
    parameter logic [NUM_BTN-1:0] BTN_IRQ_MASK   = '1
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               pll_locked_i,
    output logic               sys_arst_o,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic               irq_o,
    input  logic [NUM_BTN-1:0] irq_ack_i,
    input  logic [NUM_SW-1:0]  sw_i,
    output logic [NUM_SW-1:0]  sw_o,
    input  logic [NUM_LED-1:0] led_i,
    output logic [NUM_LED-1:0] led_o
);

    localparam int NUM_DB = NUM_BTN + NUM_SW;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

    // Synchroniser chain carries {pll_locked, switches, buttons} together.
    logic [NUM_DB:0]   sync_q [SYNC_STAGES];
    logic              lock_s;
    logic [NUM_DB-1:0] db_in;

    // NOTE: every flop gets an explicit async reset value and non-blocking assignment,
    // including arrays of flops; nothing here is a RAM, so resetting the array is free.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= {pll_locked_i, sw_i, btn_i};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1][NUM_DB];
    assign db_in  = sync_q[SYNC_STAGES-1][NUM_DB-1:0];

    logic [NUM_DB-1:0] db_q;
    logic [DB_W-1:0]   db_cnt [NUM_DB];
    logic [NUM_DB-1:0] db_rise;
    logic [NUM_BTN-1:0] press_q;

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        db_rise = '0;
        for (int i = 0; i < NUM_DB; i++)
            db_rise[i] = db_in[i] & ~db_q[i] & (db_cnt[i] == DB_LAST);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            db_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_DB; i++) db_cnt[i] <= '0;
        end else begin
            press_q <= db_rise[NUM_BTN-1:0];
            for (int i = 0; i < NUM_DB; i++) begin
                if (db_in[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_q[i]   <= db_in[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              sys_arst_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                hold_cnt_d = '0;
                if (lock_s) state_d = HOLD;
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: begin
                state_d    = WAIT_LOCK;
                hold_cnt_d = '0;
            end
        endcase
    end

    // SoC reset follows the next state so it changes on the same edge as the FSM.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            sys_arst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            sys_arst_q <= (state_d != RUN);
        end
    end

    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic               irq_q;

    // A press landing on the same cycle as its ack keeps the IRQ pending.
    always_comb begin
        pending_d = '0;
        if (state_q == RUN)
            pending_d = (pending_q & ~irq_ack_i) | (press_q & BTN_IRQ_MASK);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_q;
        end
    end

    logic [NUM_LED-1:0] led_status;

    always_comb begin
        led_status    = '0;
        led_status[0] = lock_s;
        led_status[1] = (state_q == HOLD);
    end

    assign led_o       = (state_q == RUN) ? led_i : led_status;
    assign sys_arst_o  = sys_arst_q;
    assign btn_level_o = db_q[NUM_BTN-1:0];
    assign sw_o        = db_q[NUM_DB-1:NUM_BTN];
    assign btn_press_o = press_q;
    assign irq_o       = irq_q;

endmodule
